// File: rtl/ball_motion_master.sv
// Avalon-MM write initiator that bounces a ball position once per video frame
// and pushes the new coordinates to the vga_ball registers as four byte writes.
module ball_motion_master #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int RADIUS   = 15,
  parameter int STEP_X   = 2,
  parameter int STEP_Y   = 1,
  parameter int X_INIT   = 320,
  parameter int Y_INIT   = 240
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        vga_vs,
  input  logic        waitrequest,
  output logic [2:0]  address,
  output logic [7:0]  writedata,
  output logic        write,
  output logic        chipselect,
  output logic [15:0] x_pos,
  output logic [15:0] y_pos,
  output logic        busy,
  output logic [7:0]  missed_frames
);

  localparam int XMIN = RADIUS;
  localparam int XMAX = H_ACTIVE - 1 - RADIUS;
  localparam int YMIN = RADIUS;
  localparam int YMAX = V_ACTIVE - 1 - RADIUS;

  typedef enum logic [2:0] {IDLE, UPDATE, WR_XH, WR_XL, WR_YH, WR_YL} state_t;

  state_t      state, state_next;
  logic        vs_q, tick, pending, first;
  logic        dir_x, dir_y, dir_x_next, dir_y_next;
  logic [15:0] x_next, y_next;
  logic [16:0] move_x, move_y;
  logic        write_next;
  logic [2:0]  address_next;
  logic [7:0]  writedata_next;

  // Returns {dir, pos}; dir=1 means moving toward lo.
  function automatic logic [16:0] step_axis(input logic [15:0] p, input logic neg,
                                            input int step, input int lo, input int hi);
    logic [16:0] fwd;
    fwd = {1'b0, p} + 17'(step);
    if (!neg) begin
      if (fwd >= 17'(hi)) step_axis = {1'b1, 16'(hi)};
      else                step_axis = {1'b0, fwd[15:0]};
    end else begin
      if ({1'b0, p} < 17'(lo + step)) step_axis = {1'b0, 16'(lo)};
      else                            step_axis = {1'b1, p - 16'(step)};
    end
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign tick       = vs_q & ~vga_vs;
  assign busy       = (state != IDLE);
  assign chipselect = write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        // The reset pass only publishes the initial position, no move.
        if (first)                          state_next = WR_XH;
        else if (enable && (tick || pending)) state_next = UPDATE;
      end
      UPDATE: state_next = WR_XH;
      WR_XH:  if (!waitrequest) state_next = WR_XL;
      WR_XL:  if (!waitrequest) state_next = WR_YH;
      WR_YH:  if (!waitrequest) state_next = WR_YL;
      WR_YL:  if (!waitrequest) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    move_x     = step_axis(x_pos, dir_x, STEP_X, XMIN, XMAX);
    move_y     = step_axis(y_pos, dir_y, STEP_Y, YMIN, YMAX);
    x_next     = x_pos;
    y_next     = y_pos;
    dir_x_next = dir_x;
    dir_y_next = dir_y;
    if (state == UPDATE) begin
      {dir_x_next, x_next} = move_x;
      {dir_y_next, y_next} = move_y;
    end
  end

  // Bus outputs are decoded from the next state so they are registered yet valid on entry.
  always_comb begin
    write_next     = 1'b1;
    address_next   = 3'd0;
    writedata_next = 8'd0;
    case (state_next)
      WR_XH: begin address_next = 3'd0; writedata_next = x_next[15:8]; end
      WR_XL: begin address_next = 3'd1; writedata_next = x_next[7:0];  end
      WR_YH: begin address_next = 3'd2; writedata_next = y_next[15:8]; end
      WR_YL: begin address_next = 3'd3; writedata_next = y_next[7:0];  end
      default: write_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_q      <= 1'b1;
      x_pos     <= 16'(X_INIT);
      y_pos     <= 16'(Y_INIT);
      dir_x     <= 1'b0;
      dir_y     <= 1'b0;
      write     <= 1'b0;
      address   <= 3'd0;
      writedata <= 8'd0;
    end else begin
      vs_q      <= vga_vs;
      x_pos     <= x_next;
      y_pos     <= y_next;
      dir_x     <= dir_x_next;
      dir_y     <= dir_y_next;
      write     <= write_next;
      address   <= address_next;
      writedata <= writedata_next;
    end
  end

  // One tick may queue behind a burst; later ones are only counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending       <= 1'b1;
      first         <= 1'b1;
      missed_frames <= 8'd0;
    end else if (state == IDLE) begin
      first   <= 1'b0;
      pending <= first & tick & enable;
    end else if (!enable) begin
      pending <= 1'b0;
    end else if (tick) begin
      if (pending) missed_frames <= sat_inc(missed_frames);
      else         pending       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ball_motion_master.sv
// Randomized bench for ball_motion_master: frame ticks and slave stalls against
// a frame-level position model and an expected-write queue.
module tb_ball_motion_master;
  logic        clk = 1'b0;
  logic        reset_n, enable, vga_vs, waitrequest;
  logic [2:0]  address;
  logic [7:0]  writedata;
  logic        write, chipselect, busy;
  logic [15:0] x_pos, y_pos;
  logic [7:0]  missed_frames;

  typedef struct {int cyc; logic [10:0] aw;} wr_t;
  wr_t         got_q[$];
  logic [10:0] exp_q[$];

  int checks = 0, errors = 0, cyc = 0, stall_mode = 0, stab_err = 0, cs_err = 0;
  int mx, my, mdx, mdy;
  logic        prev_stall = 1'b0;
  logic [10:0] prev_aw = '0;

  ball_motion_master dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .vga_vs(vga_vs),
    .waitrequest(waitrequest), .address(address), .writedata(writedata),
    .write(write), .chipselect(chipselect), .x_pos(x_pos), .y_pos(y_pos),
    .busy(busy), .missed_frames(missed_frames)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (stall_mode)
      1:       waitrequest = ($urandom_range(0, 2) == 0);
      2:       waitrequest = 1'b1;
      default: waitrequest = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!reset_n) prev_stall <= 1'b0;
    else begin
      if (chipselect !== write) cs_err <= cs_err + 1;
      if (prev_stall && (!write || {address, writedata} !== prev_aw)) stab_err <= stab_err + 1;
      if (write && !waitrequest) got_q.push_back('{cyc, {address, writedata}});
      prev_stall <= write && waitrequest;
      prev_aw    <= {address, writedata};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mx = 320; my = 240; mdx = 1; mdy = 1;
  endtask

  task automatic push_burst(input int x, input int y);
    exp_q.push_back({3'd0, x[15:8]});
    exp_q.push_back({3'd1, x[7:0]});
    exp_q.push_back({3'd2, y[15:8]});
    exp_q.push_back({3'd3, y[7:0]});
  endtask

  // Bounce between lo and hi: clamp at the wall and reverse.
  task automatic bounce(inout int p, inout int d, input int step, input int lo, input int hi);
    int t;
    t = p + d * step;
    if (d > 0 && t >= hi)      begin p = hi; d = -1; end
    else if (d < 0 && t < lo)  begin p = lo; d = 1;  end
    else                       p = t;
  endtask

  task automatic model_move();
    bounce(mx, mdx, 2, 15, 624);
    bounce(my, mdy, 1, 15, 464);
    push_burst(mx, my);
  endtask

  task automatic frame();
    @(posedge clk); #1 vga_vs = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 vga_vs = 1'b1;
  endtask

  task automatic wait_idle();
    int quiet = 0, n = 0;
    while (quiet < 3 && n < 3000) begin
      @(negedge clk);
      n++;
      if (!busy && !write) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic compare_writes(input string tag);
    wr_t g;
    logic [10:0] e;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_write"}, {21'd0, g.aw}, {21'd0, e});
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_gaps(input int g1, input int g2, input int g3);
    if (got_q.size() >= 4) begin
      check("gap_1", got_q[1].cyc - got_q[0].cyc, g1);
      check("gap_2", got_q[2].cyc - got_q[1].cyc, g2);
      check("gap_3", got_q[3].cyc - got_q[2].cyc, g3);
    end else check("gap_count", got_q.size(), 4);
  endtask

  task automatic check_pos(input string tag);
    check({tag, "_x"}, {16'd0, x_pos}, mx);
    check({tag, "_y"}, {16'd0, y_pos}, my);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_write"}, {31'd0, write}, 0);
    check({tag, "_cs"}, {31'd0, chipselect}, 0);
    check({tag, "_addr"}, {29'd0, address}, 0);
    check({tag, "_data"}, {24'd0, writedata}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_missed"}, {24'd0, missed_frames}, 0);
    check({tag, "_x"}, {16'd0, x_pos}, 320);
    check({tag, "_y"}, {16'd0, y_pos}, 240);
  endtask

  task automatic wait_write_addr(input logic [2:0] a);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(write && address == a) && n < 50);
    if (n >= 50) check("addr_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1; vga_vs = 1'b1; waitrequest = 1'b0;
    model_reset();

    // Power-up publish with no tick
    repeat (3) @(posedge clk);
    #1 check_reset_state("reset");
    push_burst(320, 240);
    reset_n = 1'b1;
    wait_idle();
    check_gaps(1, 1, 1);
    compare_writes("init");
    check_pos("init");

    // Stall in WR_XL for three cycles
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    push_burst(320, 240);
    wait_write_addr(3'd0);
    @(posedge clk); stall_mode = 2;
    repeat (3) @(posedge clk);
    stall_mode = 0;
    wait_idle();
    check_gaps(4, 1, 1);
    compare_writes("stall");
    check("stall_stable", stab_err, 0);

    // Random frames, random enables and stalls; crosses the x and y walls
    for (int f = 0; f < 700; f++) begin
      enable = ($urandom_range(0, 7) != 0);
      stall_mode = $urandom_range(0, 1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      frame();
      wait_idle();
      if (enable) model_move();
      compare_writes("frame");
      check_pos("frame");
    end
    stall_mode = 0;

    // Disabled frames are ignored
    enable = 1'b0;
    for (int f = 0; f < 5; f++) begin frame(); wait_idle(); end
    compare_writes("disabled");
    check_pos("disabled");
    check("disabled_missed", {24'd0, missed_frames}, 0);

    // Enable dropped mid-burst discards the pending tick
    enable = 1'b1; stall_mode = 2;
    frame(); frame();
    check("drop_busy", {31'd0, busy}, 1);
    @(posedge clk); #1 enable = 1'b0; stall_mode = 0;
    wait_idle();
    model_move();
    compare_writes("drop");
    check_pos("drop");
    enable = 1'b1;
    frame(); wait_idle();
    model_move();
    compare_writes("after_drop");
    check_pos("after_drop");

    // Pending, missed count and saturation
    stall_mode = 2;
    frame(); frame(); frame();
    check("missed_one", {24'd0, missed_frames}, 1);
    for (int f = 0; f < 300; f++) frame();
    check("missed_sat", {24'd0, missed_frames}, 255);
    stall_mode = 0;
    wait_idle();
    model_move(); model_move();
    compare_writes("pending");
    check_pos("pending");
    check("missed_hold", {24'd0, missed_frames}, 255);

    // Reset mid-WR_YH abandons the burst
    frame();
    wait_write_addr(3'd1);
    @(posedge clk); stall_mode = 2;
    @(negedge clk);
    check("yh_state", {29'd0, address}, 2);
    reset_n = 1'b0;
    #1 check_reset_state("async_reset");
    repeat (2) @(posedge clk);
    #1 stall_mode = 0;
    got_q.delete(); exp_q.delete();
    model_reset();
    push_burst(320, 240);
    reset_n = 1'b1;
    wait_idle();
    check_gaps(1, 1, 1);
    compare_writes("reinit");
    check_pos("reinit");

    check("hold_stable", stab_err, 0);
    check("cs_equals_write", cs_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
